// File: rtl/liteic_pkg.sv
// Shared types and constants for the liteic master-side arbiter.
package liteic_pkg;

  // Arbiter FSM: no grant outstanding, or a grant is being held.
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Winner-selection policies.
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Index width for a requester vector of n bits (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : liteic_pkg

// File: rtl/liteic_arbiter_chk.sv
// Invariant checker for liteic_arbiter outputs: grant is one-hot or zero,
// gnt_valid mirrors the grant, and gnt_idx encodes the granted master.
module liteic_arbiter_chk #(
  parameter int NUM_MASTERS = 20,
  parameter int IDX_WIDTH   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input logic                   clk,
  input logic                   rst,
  input logic [NUM_MASTERS-1:0] gnt,
  input logic [IDX_WIDTH-1:0]   gnt_idx,
  input logic                   gnt_valid
);

  a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

  a_valid: assert property (@(posedge clk) disable iff (rst) gnt_valid == (|gnt));

  a_encode: assert property (@(posedge clk) disable iff (rst)
    gnt_valid |-> (gnt == (NUM_MASTERS'(1'b1) << gnt_idx)));

endmodule : liteic_arbiter_chk

// File: rtl/liteic_rr_select.sv
// Combinational winner picker for the liteic arbiter.
// The request vector is doubled and masked to a window of NUM_MASTERS bits
// starting at the pointer, so a single highest-set-bit search walks the
// masters in the order ptr-1, ptr-2, ..., 0, NUM_MASTERS-1, ..., ptr.
// In fixed mode the window starts at 0, giving plain highest-index-wins.
module liteic_rr_select
  import liteic_pkg::*;
#(
  parameter int NUM_MASTERS = 20,
  parameter int IDX_WIDTH   = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_WIDTH-1:0]   ptr_i,
  input  logic                   mode_i,
  output logic [NUM_MASTERS-1:0] win_oh_o,
  output logic [IDX_WIDTH-1:0]   win_idx_o,
  output logic                   win_valid_o
);

  localparam int DW = 2 * NUM_MASTERS;

  logic [DW-1:0] dbl_s;
  int            base_s;
  int            pos_s;
  int            win_s;
  logic          hit_s;

  assign dbl_s = {req_i, req_i};

  // Start of the search window: the pointer in round-robin, bit 0 in fixed mode.
  always_comb begin
    base_s = 0;
    if (mode_i) begin
      base_s = int'(ptr_i);
    end else begin
      base_s = 0;
    end
  end

  // Highest set bit inside the window; later (higher) hits overwrite earlier ones.
  always_comb begin
    hit_s = 1'b0;
    pos_s = 0;
    for (int j = 0; j < DW; j++) begin
      hit_s = (dbl_s[j] && (j >= base_s) && (j < base_s + NUM_MASTERS)) ? 1'b1 : hit_s;
      pos_s = (dbl_s[j] && (j >= base_s) && (j < base_s + NUM_MASTERS)) ? j : pos_s;
    end
  end

  // Fold the doubled position back onto a master index and build the one-hot.
  always_comb begin
    win_s = (pos_s >= NUM_MASTERS) ? (pos_s - NUM_MASTERS) : pos_s;
    win_valid_o = hit_s;
    win_idx_o   = hit_s ? IDX_WIDTH'(win_s) : {IDX_WIDTH{1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      win_oh_o[i] = hit_s && (win_s == i);
    end
  end

endmodule : liteic_rr_select

// File: rtl/liteic_arbiter.sv
// Registered N-way arbiter for the liteic interconnect master side.
// A grant is chosen by fixed priority or round-robin, held until the
// holder strobes done, and optionally force-released by a hold watchdog.
// Releases re-arbitrate in the same cycle so back-to-back grants have no
// idle bubble.
module liteic_arbiter
  import liteic_pkg::*;
#(
  parameter int NUM_MASTERS = 20,
  parameter int IDX_WIDTH   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  parameter int RR_MODE     = ARB_RR,
  parameter int HOLD_MAX    = 256,
  parameter int CNT_WIDTH   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   done,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_WIDTH-1:0]   gnt_idx,
  output logic                   gnt_valid,
  output logic                   timeout
);

  // Watchdog fires while the counter shows HOLD_MAX-1, i.e. on the edge that
  // ends the HOLD_MAX-th granted cycle.
  localparam bit                   WD_EN      = (HOLD_MAX > 0);
  localparam int                   CNT_LAST_I = (HOLD_MAX > 0) ? (HOLD_MAX - 1) : 0;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(CNT_LAST_I);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   valid_q, valid_d;

  logic [NUM_MASTERS-1:0] win_oh_s;
  logic [IDX_WIDTH-1:0]   win_idx_s;
  logic                   win_valid_s;
  logic                   mode_s;
  logic                   expire_s;
  logic                   release_s;
  logic                   load_s;

  assign mode_s = (RR_MODE == ARB_RR) ? 1'b1 : 1'b0;

  liteic_rr_select #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_select (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .mode_i      (mode_s),
    .win_oh_o    (win_oh_s),
    .win_idx_o   (win_idx_s),
    .win_valid_o (win_valid_s)
  );

  // Release strobes: done wins over the watchdog, and an IDLE done is ignored.
  always_comb begin
    expire_s  = WD_EN && (state_q == ARB_BUSY) && (cnt_q == CNT_LAST);
    release_s = (state_q == ARB_BUSY) && (done || expire_s);
    load_s    = ((state_q == ARB_IDLE) || release_s) && win_valid_s;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: enter BUSY on any winner, leave only on a release with no requester.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (win_valid_s) begin
          state_d = ARB_BUSY;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (release_s && !win_valid_s) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_BUSY;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // FSM outputs: next grant, index, pointer, watchdog count and timeout pulse.
  always_comb begin
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = expire_s && !done;
    if (load_s) begin
      gnt_d = win_oh_s;
      idx_d = win_idx_s;
      ptr_d = win_idx_s;
      cnt_d = {CNT_WIDTH{1'b0}};
    end else if (release_s) begin
      gnt_d = {NUM_MASTERS{1'b0}};
      idx_d = {IDX_WIDTH{1'b0}};
      cnt_d = {CNT_WIDTH{1'b0}};
    end else if (WD_EN && (state_q == ARB_BUSY)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = {CNT_WIDTH{1'b0}};
    end
    valid_d = |gnt_d;
  end

  // Output and datapath registers; async reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q     <= {NUM_MASTERS{1'b0}};
      idx_q     <= {IDX_WIDTH{1'b0}};
      ptr_q     <= {IDX_WIDTH{1'b0}};
      cnt_q     <= {CNT_WIDTH{1'b0}};
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      valid_q   <= valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule : liteic_arbiter
